ame_solver_sched: RTL and testbench
===================================

AME_SOLVER_SCHED -- requirements
Module: ame_solver_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one equation solver.
REQ-002 Parameter COMP_DATA_BITS, default 64, SHALL set the matrix/result element width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1023, SHALL set the solver watchdog limit in cycles.
REQ-004 clk_i  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 req_valid_i  in  NUM_REQ  per-requester job valid.
REQ-007 req_ready_o  out  NUM_REQ  per-requester job accept; one-hot or zero.
REQ-008 req_param6_i  in  NUM_REQ  per-requester 6-parameter (1) / 4-parameter (0) affine mode.
REQ-009 req_data_i  in  NUM_REQ x 6 x 7 x COMP_DATA_BITS  per-requester augmented matrix.
REQ-010 solv_init_o  out  1  solver start pulse.
REQ-011 solv_param6_o  out  1  mode to solver.
REQ-012 solv_data_o  out  6 x 7 x COMP_DATA_BITS  matrix to solver.
REQ-013 solv_done_i  in  1  solver completion pulse.
REQ-014 solv_data_i  in  6 x COMP_DATA_BITS  solver fixed-point results.
REQ-015 rsp_valid_o / rsp_ready_i  out / in  1 / 1  response handshake.
REQ-016 rsp_id_o  out  $clog2(NUM_REQ)  index of the requester that owns the response.
REQ-017 rsp_data_o  out  6 x COMP_DATA_BITS  results.
REQ-018 rsp_timeout_o  out  1  response produced by watchdog, not by the solver.
REQ-019 busy_o  out  1  high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have four states: IDLE, LAUNCH, WAIT and RESP.
REQ-021 IDLE: if any req_valid_i bit is set, the block SHALL grant round-robin starting at last_grant+1 (wrapping at NUM_REQ), assert req_ready_o[g] combinationally that cycle, latch data, param6 and id, update last_grant=g, and move to LAUNCH.
REQ-022 LAUNCH: solv_init_o SHALL be 1 for exactly one cycle, the watchdog counter SHALL clear to 0, and the FSM SHALL move to WAIT.
REQ-023 solv_data_o and solv_param6_o SHALL be driven from the latched registers and SHALL stay stable from LAUNCH until leaving WAIT.
REQ-024 WAIT: the counter SHALL increment by 1 each cycle; solv_done_i=1 SHALL capture solv_data_i into rsp_data, clear rsp_timeout, and move to RESP.
REQ-025 WAIT: if the counter reaches TIMEOUT_CYCLES-1 without done, the block SHALL zero rsp_data, set rsp_timeout=1 and move to RESP.
REQ-026 If done and timeout occur in the same cycle, done SHALL win (rsp_timeout_o=0).
REQ-027 RESP: rsp_valid_o SHALL be 1 with stable id/data/timeout until rsp_ready_i=1; the FSM SHALL then move to IDLE.
REQ-028 solv_done_i outside WAIT SHALL be ignored.
REQ-029 req_ready_o SHALL be all-zero outside IDLE; at most one job SHALL be in flight.
REQ-030 Latency: for an accept in cycle T, solv_init_o SHALL be at T+1; for done in cycle D, rsp_valid_o SHALL be at D+1.
REQ-031 Minimum turnaround: a new accept SHALL be possible in the cycle after the RESP handshake.
REQ-032 A requester that deasserts req_valid_i before being granted SHALL lose the request without side effects.

Reset
REQ-033 rst_i=1 SHALL force IDLE, set last_grant=NUM_REQ-1, clear the counter, and drive every output to 0 (including req_ready_o, solv_init_o, rsp_valid_o, busy_o, and the data outputs).
REQ-034 Reset mid-job SHALL discard the job with no response and no further solv_init_o.

Verification
REQ-035 After reset, req_valid_i=4'b0001 -> req_ready_o=4'b0001 same cycle; solv_init_o one cycle later; solv_done_i 20 cycles later -> rsp_valid_o next cycle, rsp_id_o=0, rsp_data_o = injected values.
REQ-036 req_valid_i=4'b1111 held for 4 jobs -> grant order 0,1,2,3 and rsp_id_o sequence 0,1,2,3.
REQ-037 Solver model never asserts done, TIMEOUT_CYCLES=16 -> rsp_valid_o at cycle 16 after the WAIT entry, with rsp_timeout_o=1 and rsp_data_o=0.
REQ-038 rsp_ready_i held low 10 cycles -> rsp_* stable, req_ready_o=0, and a stray solv_done_i is ignored.
REQ-039 rst_i pulsed during WAIT -> all outputs 0 next cycle, no response; the next request from requester 0 is granted first.

Source files
------------

// File: rtl/ame_solver_sched.sv
// Round-robin scheduler that shares one affine equation solver between NUM_REQ requesters,
// with a watchdog that answers on the solver's behalf when it never completes.
`timescale 1ns/1ps
module ame_solver_sched #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned COMP_DATA_BITS = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    localparam int unsigned IdW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                                             clk_i,
    input  logic                                             rst_i,
    input  logic [NUM_REQ-1:0]                               req_valid_i,
    output logic [NUM_REQ-1:0]                               req_ready_o,
    input  logic [NUM_REQ-1:0]                               req_param6_i,
    input  logic [NUM_REQ-1:0][5:0][6:0][COMP_DATA_BITS-1:0] req_data_i,
    output logic                                             solv_init_o,
    output logic                                             solv_param6_o,
    output logic [5:0][6:0][COMP_DATA_BITS-1:0]              solv_data_o,
    input  logic                                             solv_done_i,
    input  logic [5:0][COMP_DATA_BITS-1:0]                   solv_data_i,
    output logic                                             rsp_valid_o,
    input  logic                                             rsp_ready_i,
    output logic [IdW-1:0]                                   rsp_id_o,
    output logic [5:0][COMP_DATA_BITS-1:0]                   rsp_data_o,
    output logic                                             rsp_timeout_o,
    output logic                                             busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [IdW-1:0]                          last_q, last_d;
    logic [IdW-1:0]                          id_q, id_d;
    logic [5:0][6:0][COMP_DATA_BITS-1:0]     data_q, data_d;
    logic                                    param6_q, param6_d;
    logic [CntW-1:0]                         cnt_q, cnt_d;
    logic [5:0][COMP_DATA_BITS-1:0]          rsp_data_q, rsp_data_d;
    logic                                    timeout_q, timeout_d;

    logic                                    grant_vld;
    logic [IdW-1:0]                          grant_idx;
    int unsigned                             cand;
    logic                                    wd_expired;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = 32'(last_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_vld && req_valid_i[IdW'(cand)]) begin
                grant_vld = 1'b1;
                grant_idx = IdW'(cand);
            end
        end
    end

    assign wd_expired = (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    state_d = StLaunch;
                end
            end
            StLaunch: begin
                state_d = StWait;
            end
            StWait: begin
                if (solv_done_i || wd_expired) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs; combinational strobes are forced low while reset is asserted.
    always_comb begin
        req_ready_o = '0;
        if (!rst_i && state_q == StIdle && grant_vld) begin
            req_ready_o[grant_idx] = 1'b1;
        end
        solv_init_o   = !rst_i && (state_q == StLaunch);
        rsp_valid_o   = !rst_i && (state_q == StResp);
        busy_o        = !rst_i && (state_q != StIdle);
        solv_data_o   = rst_i ? '0 : data_q;
        solv_param6_o = !rst_i && param6_q;
        rsp_id_o      = rst_i ? '0 : id_q;
        rsp_data_o    = rst_i ? '0 : rsp_data_q;
        rsp_timeout_o = !rst_i && timeout_q;
    end

    // Datapath next-state: job latch, watchdog and response capture.
    always_comb begin
        last_d     = last_q;
        id_d       = id_q;
        data_d     = data_q;
        param6_d   = param6_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) begin
                    last_d   = grant_idx;
                    id_d     = grant_idx;
                    data_d   = req_data_i[grant_idx];
                    param6_d = req_param6_i[grant_idx];
                end
            end
            StLaunch: begin
                cnt_d = '0;
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                // A completion in the watchdog's final cycle still counts as a real result.
                if (solv_done_i) begin
                    rsp_data_d = solv_data_i;
                    timeout_d  = 1'b0;
                end else if (wd_expired) begin
                    rsp_data_d = '0;
                    timeout_d  = 1'b1;
                end
            end
            StResp: begin
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q     <= IdW'(NUM_REQ - 1);
            id_q       <= '0;
            data_q     <= '0;
            param6_q   <= 1'b0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            last_q     <= last_d;
            id_q       <= id_d;
            data_q     <= data_d;
            param6_q   <= param6_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule

// File: tb/tb_ame_solver_sched.sv
// Randomized scoreboard bench for ame_solver_sched plus a directed watchdog check on a
// second instance with a short timeout.
`timescale 1ns/1ps
module tb_ame_solver_sched;
    localparam int N    = 4;
    localparam int W    = 64;
    localparam int TO   = 32;
    localparam int TO_S = 16;

    typedef logic [5:0][6:0][W-1:0] mat_t;
    typedef logic [5:0][W-1:0]      res_t;
    typedef struct { int id; mat_t data; logic p6; int cyc; } launch_t;
    typedef struct { int id; res_t data; logic to; int cyc; } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                           rst_i;
    logic [N-1:0]                   req_valid, req_ready, req_param6;
    logic [N-1:0][5:0][6:0][W-1:0]  req_data;
    logic                           solv_init, solv_param6, solv_done;
    mat_t                           solv_data;
    res_t                           solv_res;
    logic                           rsp_valid, rsp_ready, rsp_timeout, busy;
    logic [1:0]                     rsp_id;
    res_t                           rsp_data;

    logic [N-1:0]                   to_valid, to_ready, to_param6;
    logic [N-1:0][5:0][6:0][W-1:0]  to_data;
    logic                           to_init, to_p6o, to_done, to_rsp_valid, to_rsp_ready;
    logic                           to_rsp_to, to_busy;
    mat_t                           to_sdata;
    res_t                           to_sres, to_rsp_data;
    logic [1:0]                     to_rsp_id;

    ame_solver_sched #(.NUM_REQ(N), .COMP_DATA_BITS(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_param6_i(req_param6), .req_data_i(req_data), .solv_init_o(solv_init),
        .solv_param6_o(solv_param6), .solv_data_o(solv_data), .solv_done_i(solv_done),
        .solv_data_i(solv_res), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_id_o(rsp_id), .rsp_data_o(rsp_data), .rsp_timeout_o(rsp_timeout), .busy_o(busy)
    );

    ame_solver_sched #(.NUM_REQ(N), .COMP_DATA_BITS(W), .TIMEOUT_CYCLES(TO_S)) dut_to (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(to_valid), .req_ready_o(to_ready),
        .req_param6_i(to_param6), .req_data_i(to_data), .solv_init_o(to_init),
        .solv_param6_o(to_p6o), .solv_data_o(to_sdata), .solv_done_i(to_done),
        .solv_data_i(to_sres), .rsp_valid_o(to_rsp_valid), .rsp_ready_i(to_rsp_ready),
        .rsp_id_o(to_rsp_id), .rsp_data_o(to_rsp_data), .rsp_timeout_o(to_rsp_to),
        .busy_o(to_busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int first_diff(mat_t a, mat_t b);
        for (int k = 0; k < 42; k++) if (a[k/7][k%7] !== b[k/7][k%7]) return k;
        return 0;
    endfunction

    function automatic res_t rand_res();
        res_t r;
        for (int i = 0; i < 6; i++) r[i] = {$urandom, $urandom};
        return r;
    endfunction

    // Round-robin reference: first valid requester after the previous winner.
    function automatic int pick(logic [N-1:0] v, int last);
        for (int i = 1; i <= N; i++) if (v[(last + i) % N]) return (last + i) % N;
        return -1;
    endfunction

    launch_t launch_q[$];
    rsp_t    rsp_q[$];
    int      grant_log[$];
    int      id_log[$];
    bit      model_free  = 1'b1;
    int      model_last  = N - 1;
    bit      rsp_started = 1'b0;
    bit      in_wait     = 1'b0;
    mat_t    cur_data;
    logic    cur_p6;

    int      force_k   = -1;
    int      stray_pct = 25;
    int      sol_k     = 0;
    res_t    sol_res;
    bit      pending   = 1'b0;
    int      k_left    = 0;

    // Solver model: done k cycles into WAIT, never if k is past the watchdog; stray dones
    // are thrown in whenever no job is waiting.
    initial begin
        solv_done = 1'b0;
        solv_res  = '0;
        forever begin
            @(posedge clk);
            #2;
            solv_done = 1'b0;
            solv_res  = rand_res();
            if (rst_i) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    if (k_left == 0) begin
                        solv_done = 1'b1;
                        solv_res  = sol_res;
                        pending   = 1'b0;
                    end else begin
                        k_left--;
                    end
                end else if ((!busy || rsp_valid || solv_init) &&
                             $urandom_range(99) < stray_pct) begin
                    solv_done = 1'b1;
                end
                if (solv_init) begin
                    sol_k   = (force_k >= 0) ? force_k : int'($urandom_range(TO + 4));
                    sol_res = rand_res();
                    if (sol_k <= TO - 1) begin
                        pending = 1'b1;
                        k_left  = sol_k;
                    end
                end
            end
        end
    end

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        launch_t l;
        rsp_t    r;
        int      g, k;
        if (rst_i) begin
            launch_q.delete();
            rsp_q.delete();
            model_free  = 1'b1;
            model_last  = N - 1;
            rsp_started = 1'b0;
            in_wait     = 1'b0;
        end else begin
            chk("busy", busy, !model_free);
            exp_ready = '0;
            if (model_free) begin
                g = pick(req_valid, model_last);
                if (g >= 0) begin
                    exp_ready[g] = 1'b1;
                    l.id = g; l.data = req_data[g]; l.p6 = req_param6[g]; l.cyc = cyc;
                    launch_q.push_back(l);
                    model_free = 1'b0;
                    model_last = g;
                end
            end
            chk("req_ready", req_ready, exp_ready);
            for (int i = 0; i < N; i++) if (req_ready[i]) grant_log.push_back(i);

            if (solv_init) begin
                if (launch_q.size() == 0) begin
                    chk("solv_init_unexpected", solv_init, 1'b0);
                end else begin
                    l = launch_q.pop_front();
                    chk("init_latency", cyc, l.cyc + 1);
                    k = first_diff(solv_data, l.data);
                    chk("solv_data", solv_data[k/7][k%7], l.data[k/7][k%7]);
                    chk("solv_param6", solv_param6, l.p6);
                    cur_data = l.data;
                    cur_p6   = l.p6;
                    in_wait  = 1'b1;
                    r.id = l.id;
                    if (sol_k <= TO - 1) begin
                        r.data = sol_res; r.to = 1'b0; r.cyc = cyc + 2 + sol_k;
                    end else begin
                        r.data = '0; r.to = 1'b1; r.cyc = cyc + 1 + TO;
                    end
                    rsp_q.push_back(r);
                end
            end else if (launch_q.size() > 0 && cyc > launch_q[0].cyc + 1) begin
                chk("solv_init_missing", solv_init, 1'b1);
                void'(launch_q.pop_front());
                model_free = 1'b1;
            end

            if (in_wait && !rsp_valid) begin
                k = first_diff(solv_data, cur_data);
                chk("solv_data_hold", solv_data[k/7][k%7], cur_data[k/7][k%7]);
                chk("solv_param6_hold", solv_param6, cur_p6);
            end

            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    if (!rsp_started) begin
                        chk("rsp_latency", cyc, rsp_q[0].cyc);
                        rsp_started = 1'b1;
                        in_wait     = 1'b0;
                    end
                    chk("rsp_id", rsp_id, rsp_q[0].id);
                    chk("rsp_data", rsp_data, rsp_q[0].data);
                    chk("rsp_timeout", rsp_timeout, rsp_q[0].to);
                    if (rsp_ready) begin
                        id_log.push_back(int'(rsp_id));
                        void'(rsp_q.pop_front());
                        rsp_started = 1'b0;
                        model_free  = 1'b1;
                    end
                end
            end else if (rsp_q.size() > 0 && cyc > rsp_q[0].cyc) begin
                chk("rsp_missing", rsp_valid, 1'b1);
                void'(rsp_q.pop_front());
                model_free = 1'b1;
                in_wait    = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_reqs();
        for (int r = 0; r < N; r++)
            for (int i = 0; i < 6; i++)
                for (int j = 0; j < 7; j++) req_data[r][i][j] = {$urandom, $urandom};
        req_param6 = N'($urandom);
    endtask

    task automatic do_reset();
        step();
        rst_i = 1'b1;
        repeat (2) step();
        rst_i = 1'b0;
    endtask

    task automatic drain();
        bit done_ok;
        done_ok = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (!busy && launch_q.size() == 0 && rsp_q.size() == 0) begin
                done_ok = 1'b1;
                break;
            end
        end
        if (!done_ok) chk("drain_idle", busy, 1'b0);
    endtask

    initial begin
        int l_cyc, v_cyc;
        rst_i = 1'b1; req_valid = '0; req_param6 = '0; req_data = '0; rsp_ready = 1'b1;
        to_valid = '0; to_param6 = '0; to_data = '0; to_done = 1'b0; to_sres = '0;
        to_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_solv_init", solv_init, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_solv_data", solv_data[0][0], '0);
        step();
        rst_i = 1'b0;

        // Single job from requester 0, done 20 cycles after init.
        rand_reqs();
        force_k   = 19;
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        drain();

        // All four requesting continuously after reset: order 0,1,2,3.
        do_reset();
        force_k = -1;
        grant_log.delete();
        id_log.delete();
        req_valid = 4'b1111;
        for (int i = 0; i < 400 && grant_log.size() < 4; i++) begin
            rand_reqs();
            step();
        end
        drain();
        chk("grant_count", grant_log.size(), 4);
        chk("rsp_count", id_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("grant_order", grant_log[i], i);
        for (int i = 0; i < 4 && i < id_log.size(); i++) chk("rsp_id_order", id_log[i], i);

        // Response back-pressured for 10 cycles with stray dones flying around.
        rand_reqs();
        stray_pct = 60;
        force_k   = 5;
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        for (int i = 0; i < 60 && !rsp_valid; i++) step();
        repeat (10) begin
            req_valid = 4'b1011;
            step();
        end
        stray_pct = 25;
        force_k   = -1;
        drain();

        // Random traffic with random back-pressure, including watchdog expiries.
        for (int i = 0; i < 900; i++) begin
            rand_reqs();
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(99) < 70);
            step();
        end
        drain();

        // Reset in the middle of WAIT on a job from requester 2.
        force_k   = 1000;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (4) step();
        chk("pre_reset_busy", busy, 1'b1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_init", solv_init, 1'b0);
        chk("post_rst_rsp_valid", rsp_valid, 1'b0);
        chk("post_rst_rsp_id", rsp_id, '0);
        chk("post_rst_rsp_data", rsp_data, '0);
        chk("post_rst_solv_data", solv_data[5][6], '0);
        chk("post_rst_solv_p6", solv_param6, 1'b0);
        step();
        force_k   = -1;
        req_valid = 4'b1111;
        @(negedge clk);
        chk("post_rst_grant", req_ready, 4'b0001);
        step();
        drain();

        // Watchdog on the short-timeout instance; its solver never completes.
        step();
        to_valid = 4'b0010;
        @(negedge clk);
        chk("to_grant", to_ready, 4'b0010);
        step();
        to_valid = '0;
        l_cyc = -1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (to_init) begin
                l_cyc = cyc;
                break;
            end
        end
        if (l_cyc < 0) begin
            chk("to_init_missing", to_init, 1'b1);
        end else begin
            v_cyc = -1;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (to_rsp_valid) begin
                    v_cyc = cyc;
                    break;
                end
            end
            if (v_cyc < 0) begin
                chk("to_rsp_missing", to_rsp_valid, 1'b1);
            end else begin
                chk("to_latency", v_cyc - (l_cyc + 1), TO_S);
                chk("to_timeout", to_rsp_to, 1'b1);
                chk("to_rsp_data", to_rsp_data, '0);
                chk("to_rsp_id", to_rsp_id, 1);
                @(posedge clk);
                @(negedge clk);
                chk("to_idle", to_busy, 1'b0);
            end
        end

        repeat (3) step();
        chk("scoreboard_empty", launch_q.size() + rsp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "global timeout");
    end

endmodule
